// File: rtl/rr_burst_scheduler_if.sv
// Request/grant and beat handshake bundle between requesters, the shared resource and the
// round-robin burst scheduler.
interface rr_burst_scheduler_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LEN_W = 4
);
  localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req;
  logic [N_REQ*LEN_W-1:0] req_len;
  logic                   beat_ready;
  logic [N_REQ-1:0]       grant;
  logic [OW-1:0]          owner;
  logic                   busy;
  logic                   beat_valid;
  logic                   done;
  logic                   timeout_err;

  // Requester ring plus resource side: drives requests and beat_ready, observes the grant.
  modport master (
    output req, req_len, beat_ready,
    input  grant, owner, busy, beat_valid, done, timeout_err
  );

  // Scheduler side.
  modport slave (
    input  req, req_len, beat_ready,
    output grant, owner, busy, beat_valid, done, timeout_err
  );
endinterface

// File: rtl/rr_burst_scheduler.sv
// Round-robin burst scheduler: grants one requester a whole burst of beats, releasing on the
// last accepted beat or after a run of stalled cycles.
module rr_burst_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input logic                 clock,
  input logic                 reset,
  rr_burst_scheduler_if.slave bus
);

  localparam int unsigned OW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned OW1 = OW + 1;
  localparam int unsigned SW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [OW-1:0]    ptr_q, ptr_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] beat_q, beat_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic             tmo_q, tmo_d;

  // Arbitration: rotate requests so the pointer sits at bit 0, then take the lowest set bit.
  logic [2*N_REQ-1:0] req_dbl;
  logic               any_req;
  logic [OW1-1:0]     wsum;
  logic [OW-1:0]      winner;
  logic [N_REQ-1:0]   win_onehot;
  logic [LEN_W-1:0]   win_len;

  always_comb begin
    req_dbl = {bus.req, bus.req} >> ptr_q;
    any_req = 1'b0;
    wsum    = '0;
    for (int k = 0; k < int'(N_REQ); k++) begin
      if (!any_req && req_dbl[k]) begin
        any_req = 1'b1;
        wsum    = {1'b0, ptr_q} + OW1'(k);
      end
    end
    winner = (wsum >= OW1'(N_REQ)) ? OW'(wsum - OW1'(N_REQ)) : OW'(wsum);

    win_onehot = '0;
    win_len    = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (winner == OW'(i)) begin
        win_onehot[i] = 1'b1;
        win_len       = bus.req_len[i*LEN_W +: LEN_W];
      end
    end
  end

  logic             beat_last;
  logic             stall_last;
  logic [OW-1:0]    ptr_after;

  always_comb begin
    beat_last  = (beat_q + LEN_W'(1)) == len_q;
    stall_last = (stall_q + SW'(1)) == SW'(TIMEOUT);
    ptr_after  = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    len_d   = len_q;
    beat_d  = beat_q;
    stall_d = stall_q;
    tmo_d   = 1'b0;

    case (state_q)
      BURST: begin
        if (bus.beat_ready) begin
          // An accepted beat always wins over a stall timeout in the same cycle.
          beat_d  = beat_q + LEN_W'(1);
          stall_d = '0;
          if (beat_last) begin
            state_d = DONE;
            grant_d = '0;
            ptr_d   = ptr_after;
          end
        end else begin
          stall_d = stall_q + SW'(1);
          if (stall_last) begin
            state_d = DONE;
            grant_d = '0;
            ptr_d   = ptr_after;
            tmo_d   = 1'b1;
          end
        end
      end
      default: begin
        // IDLE and DONE both arbitrate, so back-to-back bursts have a single gap cycle.
        if (any_req) begin
          state_d = BURST;
          grant_d = win_onehot;
          owner_d = winner;
          len_d   = (win_len == '0) ? LEN_W'(1) : win_len;
          beat_d  = '0;
          stall_d = '0;
        end else begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      stall_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      stall_q <= stall_d;
      tmo_q   <= tmo_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.owner       = owner_q;
  assign bus.busy        = (state_q == BURST);
  assign bus.beat_valid  = (state_q == BURST);
  assign bus.done        = (state_q == DONE);
  assign bus.timeout_err = tmo_q;

  grant_onehot_a: assert property (@(posedge clock) disable iff (reset) $onehot0(grant_q));
  grant_stable_a: assert property (@(posedge clock) disable iff (reset)
    (state_q == BURST && state_d == BURST) |=> $stable(grant_q));

endmodule
